// File: rtl/clock_controller.sv
// clock_controller: state sequencer for the six-digit 12-hour display.
// Decodes push-button pulses into the shared state code, generates the
// one-second advance pulse, and owns set-mode digit editing.
// Optional feature: define BLINK_EN to add the blinkMask output, which
// blinks the selected digit while in set mode.

module clock_controller #(
    parameter int unsigned TICK_DIV   = 50000000,
    parameter logic [23:0] RESET_TIME = 24'h120000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pbReset,
    input  logic        pbSet,
    input  logic        pbStart,
    input  logic        pbNext,
    input  logic        pbInc,
    input  logic [23:0] currentBits,
`ifdef BLINK_EN
    output logic [5:0]  blinkMask,
`endif
    output logic [3:0]  state,
    output logic        rCount,
    output logic [23:0] setBits,
    output logic [2:0]  digitSel
);

    localparam int unsigned CntW = $clog2(TICK_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    typedef enum logic [3:0] {
        StReset = 4'd0,
        StSet   = 4'd1,
        StRun   = 4'd3,
        StIdle  = 4'd4
    } stateT;

    stateT            stateQ, stateD;
    logic [CntW-1:0]  cntQ, cntD;
    logic [23:0]      setBitsQ, setBitsD;
    logic [2:0]       digitSelQ, digitSelD;
    logic [3:0]       newHhb;
    logic             counting;

    // Increment v within [lo, hi]; anything at or past hi (or below lo) wraps to lo.
    function automatic logic [3:0] incWrap(input logic [3:0] v, input logic [3:0] lo,
                                           input logic [3:0] hi);
        return (v >= hi || v < lo) ? lo : v + 4'd1;
    endfunction

`ifdef BLINK_EN
    assign counting = (stateQ == StRun) || (stateQ == StSet);
`else
    assign counting = (stateQ == StRun);
`endif

    // Next-state decode; pbReset dominates, then pbStart, then pbSet.
    always_comb begin
        stateD = stateQ;
        if (pbReset) begin
            stateD = StReset;
        end else begin
            case (stateQ)
                StReset: stateD = StIdle;
                StIdle: begin
                    if (pbStart)    stateD = StRun;
                    else if (pbSet) stateD = StSet;
                end
                StSet:   if (pbStart) stateD = StRun;
                StRun:   stateD = StRun;
                default: stateD = StReset;
            endcase
        end
    end

    // Tick counter: cleared on any state entry, free-running while counting.
    always_comb begin
        cntD = cntQ;
        if (pbReset || (stateD != stateQ)) begin
            cntD = '0;
        end else if (counting) begin
            cntD = (cntQ == CntMax) ? '0 : cntQ + CntW'(1);
        end
    end

    // Set-value and digit-select editing, with 12-hour legality repair.
    always_comb begin
        setBitsD  = setBitsQ;
        digitSelD = digitSelQ;
        newHhb    = incWrap(setBitsQ[23:20], 4'd0, 4'd1);
        if (pbReset) begin
            setBitsD  = RESET_TIME;
            digitSelD = 3'd6;
        end else if (stateQ == StIdle && pbSet && !pbStart) begin
            setBitsD  = currentBits;
            digitSelD = 3'd6;
        end else if (stateQ == StSet && !pbStart) begin
            if (pbInc) begin
                case (digitSelQ)
                    3'd1: setBitsD[3:0]   = incWrap(setBitsQ[3:0], 4'd0, 4'd9);
                    3'd2: setBitsD[7:4]   = incWrap(setBitsQ[7:4], 4'd0, 4'd5);
                    3'd3: setBitsD[11:8]  = incWrap(setBitsQ[11:8], 4'd0, 4'd9);
                    3'd4: setBitsD[15:12] = incWrap(setBitsQ[15:12], 4'd0, 4'd5);
                    3'd5: begin
                        if (setBitsQ[23:20] == 4'd0)
                            setBitsD[19:16] = incWrap(setBitsQ[19:16], 4'd1, 4'd9);
                        else
                            setBitsD[19:16] = incWrap(setBitsQ[19:16], 4'd0, 4'd2);
                    end
                    3'd6: begin
                        setBitsD[23:20] = newHhb;
                        // Keep the hour legal when the tens digit changes.
                        if (newHhb == 4'd1 && setBitsQ[19:16] > 4'd2)
                            setBitsD[19:16] = 4'd2;
                        else if (newHhb == 4'd0 && setBitsQ[19:16] == 4'd0)
                            setBitsD[19:16] = 4'd1;
                    end
                    default: ;
                endcase
            end
            if (pbNext) begin
                digitSelD = (digitSelQ <= 3'd1 || digitSelQ > 3'd6) ? 3'd6
                                                                      : digitSelQ - 3'd1;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= StReset;
            cntQ      <= '0;
            setBitsQ  <= RESET_TIME;
            digitSelQ <= 3'd6;
        end else begin
            stateQ    <= stateD;
            cntQ      <= cntD;
            setBitsQ  <= setBitsD;
            digitSelQ <= digitSelD;
        end
    end

`ifdef BLINK_EN
    // First half of each tick period lights the selected digit's bit.
    always_comb begin
        blinkMask = '0;
        if (stateQ == StSet && cntQ < CntW'(TICK_DIV / 2) &&
            digitSelQ >= 3'd1 && digitSelQ <= 3'd6)
            blinkMask = 6'b000001 << (digitSelQ - 3'd1);
    end
`endif

    assign state    = stateQ;
    assign rCount   = (stateQ == StRun) && (cntQ == CntMax);
    assign setBits  = setBitsQ;
    assign digitSel = digitSelQ;

endmodule

// File: tb/tb_clock_controller.sv
// Directed bench for clock_controller with TICK_DIV=4.
module tb_clock_controller;

    localparam int unsigned TickDiv = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pbReset, pbSet, pbStart, pbNext, pbInc;
    logic [23:0] currentBits;
    logic [3:0]  state;
    logic        rCount;
    logic [23:0] setBits;
    logic [2:0]  digitSel;
`ifdef BLINK_EN
    logic [5:0]  blinkMask;
`endif

    int nVectors = 0;
    int nMiscompares = 0;

    always #5 clk = ~clk;

    clock_controller #(
        .TICK_DIV  (TickDiv),
        .RESET_TIME(24'h120000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pbReset    (pbReset),
        .pbSet      (pbSet),
        .pbStart    (pbStart),
        .pbNext     (pbNext),
        .pbInc      (pbInc),
        .currentBits(currentBits),
`ifdef BLINK_EN
        .blinkMask  (blinkMask),
`endif
        .state      (state),
        .rCount     (rCount),
        .setBits    (setBits),
        .digitSel   (digitSel)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVectors++;
        if (got !== exp) begin
            nMiscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic r, input logic s, input logic st, input logic n,
                         input logic i);
        pbReset = r; pbSet = s; pbStart = st; pbNext = n; pbInc = i;
        step();
        pbReset = 0; pbSet = 0; pbStart = 0; pbNext = 0; pbInc = 0;
    endtask

    // Reset button, then let RESET fall through to IDLE.
    task automatic pressReset();
        pulse(1, 0, 0, 0, 0);
        checkEq("reset_state", 32'(state), 32'd0);
        step();
        checkEq("reset_to_idle", 32'(state), 32'd4);
    endtask

    initial begin
        rst_n = 0;
        pbReset = 0; pbSet = 0; pbStart = 0; pbNext = 0; pbInc = 0;
        currentBits = 24'h0;

        // Asynchronous reset values
        #12;
        checkEq("rst_state", 32'(state), 32'd0);
        checkEq("rst_rCount", 32'(rCount), 32'd0);
        checkEq("rst_setBits", 32'(setBits), 32'h120000);
        checkEq("rst_digitSel", 32'(digitSel), 32'd6);
        rst_n = 1;
        #1;
        checkEq("release_state", 32'(state), 32'd0);
        step();
        checkEq("idle_state", 32'(state), 32'd4);
        checkEq("idle_rCount", 32'(rCount), 32'd0);

        // Counting: counter is 0 in the first RUN cycle, so rCount is high in
        // the 4th, 8th and 12th cycles of RUN (n = 3, 7, 11 here).
        pulse(0, 0, 1, 0, 0);
        checkEq("run_state", 32'(state), 32'd3);
        for (int n = 0; n < 13; n++) begin
            checkEq($sformatf("rCount_n%0d", n), 32'(rCount),
                    ((n % 4) == 3) ? 32'd1 : 32'd0);
            step();
        end

        // pbSet and pbNext/pbInc ignored in RUN
        pulse(0, 1, 0, 1, 1);
        checkEq("run_ignores_set", 32'(state), 32'd3);
        checkEq("run_holds_setBits", 32'(setBits), 32'h120000);

        // pbReset beats pbStart
        pulse(1, 0, 1, 0, 0);
        checkEq("prio_reset_state", 32'(state), 32'd0);
        checkEq("prio_reset_rCount", 32'(rCount), 32'd0);
        step();
        checkEq("prio_then_idle", 32'(state), 32'd4);

        // Editing
        currentBits = 24'h115958;
        pulse(0, 1, 0, 0, 0);
        checkEq("set_state", 32'(state), 32'd1);
        checkEq("set_load", 32'(setBits), 32'h115958);
        checkEq("set_digitSel", 32'(digitSel), 32'd6);
        currentBits = 24'h000000;
        step();
        checkEq("set_holds_load", 32'(setBits), 32'h115958);
        for (int k = 0; k < 5; k++) pulse(0, 0, 0, 1, 0);
        checkEq("next_to_lsb", 32'(digitSel), 32'd1);
        pulse(0, 0, 0, 0, 1);
        checkEq("lsb_inc_9", 32'(setBits), 32'h115959);
        pulse(0, 0, 0, 0, 1);
        checkEq("lsb_wrap_0", 32'(setBits), 32'h115950);
        pulse(0, 0, 0, 1, 0);
        checkEq("next_wrap_6", 32'(digitSel), 32'd6);
        pulse(0, 0, 0, 1, 0);
        pulse(0, 0, 0, 1, 0);
        pulse(0, 0, 0, 1, 0);
        pulse(0, 0, 0, 1, 0);
        checkEq("sel_hsb", 32'(digitSel), 32'd2);
        pulse(0, 0, 0, 0, 1);
        checkEq("hsb_wrap_0", 32'(setBits), 32'h115900);
        pulse(1, 0, 0, 0, 0);
        checkEq("set_reset_bits", 32'(setBits), 32'h120000);
        checkEq("set_reset_sel", 32'(digitSel), 32'd6);
        step();

        // Hour legality: 09 -> 12 -> 02
        currentBits = 24'h090000;
        pulse(0, 1, 0, 0, 0);
        checkEq("load_09", 32'(setBits), 32'h090000);
        pulse(0, 0, 0, 0, 1);
        checkEq("hhb_09_to_12", 32'(setBits), 32'h120000);
        pulse(0, 0, 0, 0, 1);
        checkEq("hhb_12_to_02", 32'(setBits), 32'h020000);

        // LHB with HHB=0 wraps 9 -> 1
        pulse(0, 0, 0, 1, 0);
        for (int k = 0; k < 7; k++) pulse(0, 0, 0, 0, 1);
        checkEq("lhb_up_to_9", 32'(setBits), 32'h090000);
        pulse(0, 0, 0, 0, 1);
        checkEq("lhb_wrap_1", 32'(setBits), 32'h010000);

        // Inc and Next together: inc hits LHB, select moves to HMB
        pulse(0, 0, 0, 1, 1);
        checkEq("incnext_bits", 32'(setBits), 32'h020000);
        checkEq("incnext_sel", 32'(digitSel), 32'd4);

        // Start from SET, setBits holds
        pulse(0, 0, 1, 0, 0);
        checkEq("set_to_run", 32'(state), 32'd3);
        step();
        step();
        checkEq("run_holds_bits", 32'(setBits), 32'h020000);

        // 10 -> HHB inc gives 01
        pressReset();
        currentBits = 24'h100000;
        pulse(0, 1, 0, 0, 0);
        pulse(0, 0, 0, 0, 1);
        checkEq("hhb_10_to_01", 32'(setBits), 32'h010000);

        // pbSet in SET is ignored
        pulse(0, 1, 0, 0, 0);
        checkEq("set_ignores_set", 32'(state), 32'd1);

`ifdef BLINK_EN
        pressReset();
        checkEq("blink_idle", 32'(blinkMask), 32'd0);
        pulse(0, 1, 0, 0, 0);
        for (int n = 0; n < 6; n++) begin
            checkEq($sformatf("blink_n%0d", n), 32'(blinkMask),
                    ((n % 4) < 2) ? 32'h20 : 32'h0);
            step();
        end
        pulse(0, 0, 1, 0, 0);
        checkEq("blink_run", 32'(blinkMask), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/clock_controller.md
Name: clock_controller

Overview:
Sequencer for the six-digit 12-hour time display (LSB, HSB, LMB, HMB, LHB, HHB digit slices).
- Converts debounced push-button pulses into the shared 4-bit state code.
- Generates the one-second advance pulse (rCount) consumed by every digit slice.
- Owns set-mode editing and drives a packed 24-bit set value, one nibble per digit, with 12-hour legality enforced.

Parameters:
TICK_DIV, 50000000, clk cycles per rCount pulse (one second at 50 MHz); minimum 2.
RESET_TIME, 24'h120000, packed BCD time loaded on reset, HHB in [23:20] down to LSB in [3:0].

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
pbReset  input  1  one-cycle debounced pulse, reset button
pbSet  input  1  one-cycle pulse, enter set mode
pbStart  input  1  one-cycle pulse, start counting
pbNext  input  1  one-cycle pulse, select next digit (set mode only)
pbInc  input  1  one-cycle pulse, increment selected digit (set mode only)
currentBits  input  24  packed live digit values from the digit slices
state  output  4  state code to digit slices: 0 reset, 1 set, 3 start, 4 idle
rCount  output  1  one-cycle advance pulse, active only in start
setBits  output  24  packed edit value; nibble k drives digit k setBits
digitSel  output  3  selected digit identity 1..6 (1=LSB … 6=HHB)

Behaviour:
- Reset (rst_n low), asynchronous:
  - state=0, rCount=0, digitSel=6.
  - setBits=RESET_TIME.
  - tick counter=0.
- FSM states and codes: RESET(0), IDLE(4), SET(1), RUN(3). state is registered and changes the cycle after the causing pulse.
- Button priority within one cycle: pbReset > pbStart > pbSet > pbNext/pbInc.
- pbReset in any state:
  - next state RESET; setBits=RESET_TIME; digitSel=6; tick counter cleared.
  - RESET lasts exactly one cycle (unless pbReset repeats), then goes to IDLE.
- IDLE: pbSet -> SET; pbStart -> RUN.
- SET:
  - pbStart -> RUN; pbSet ignored.
  - On entry, setBits loads currentBits and digitSel=6.
- RUN:
  - Only pbReset leaves. pbSet, pbNext and pbInc are ignored; RUN never goes directly to SET.
  - Tick counter counts 0..TICK_DIV-1 and wraps.
  - rCount=1 for exactly the cycle in which the counter equals TICK_DIV-1.
  - Counter cleared on entry to RUN, so the first rCount comes TICK_DIV cycles after state becomes 3.
  - rCount is 0 in all other states.
- Set editing (SET only):
  - pbNext: digitSel decrements 6→5→…→1, then wraps to 6.
  - pbInc increments the selected nibble with wrap:
    - LSB, LMB: 0..9.
    - HSB, HMB: 0..5.
    - HHB: 0..1.
    - LHB when HHB=0: 1..9 (9 wraps to 1).
    - LHB when HHB=1: 0..2 (2 wraps to 0).
  - Hour legality is repaired in the same cycle as an HHB change:
    - HHB 0→1 with LHB>2 forces LHB=2.
    - HHB 1→0 with LHB=0 forces LHB=1.
  - pbInc and pbNext in the same cycle: the increment applies to the currently selected digit, and digitSel advances.
- setBits holds its value outside SET.
- Illegal internal state: recover to RESET.

Optional Feature:
Macro BLINK_EN.
- Defined: adds output blinkMask[5:0].
  - In SET, the bit for digitSel-1 toggles every TICK_DIV/2 cycles; all other bits are 0.
  - The blink counter is shared with the tick counter and runs in SET.
  - blinkMask=0 outside SET and at reset.
- Undefined: no port and no extra logic; the tick counter runs only in RUN.

Test Plan:
- Reset and release: rst_n low, then high -> state=0 for one cycle, then 4; setBits=24'h120000; rCount stays 0.
- Counting: TICK_DIV=4, pbStart from IDLE -> state=3 next cycle; rCount high on cycles 4, 8, 12 after entry, each one cycle wide.
- Editing: pbSet with currentBits=24'h115958 -> setBits=24'h115958, digitSel=6. Then 5 pbNext -> digitSel=1; 2 pbInc -> LSB 8→9→0.
- Hour legality:
  - setBits=24'h090000, pbInc on HHB -> setBits=24'h120000.
  - pbInc on HHB again -> 24'h020000.
  - With 24'h100000, pbInc on HHB -> 24'h010000.
- Priority: pbReset and pbStart in the same cycle from RUN -> state=0 next cycle. pbSet during RUN -> state remains 3.
- BLINK_EN: in SET with TICK_DIV=4, digitSel=6 -> blinkMask toggles between 6'b100000 and 0 every 2 cycles; pbStart -> blinkMask=0.
